// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS32 front end: fetch FSM state encoding,
// PC arithmetic constants, jump-target field widths and a word-align helper.
// -----------------------------------------------------------------------------
package mips_pkg;

    // Fetch control FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERROR  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // J-type target: {pc4[31:28], instr[25:0], 2'b00}
    localparam int JMP_INDEX_W  = 26;
    localparam int JMP_REGION_W = 4;

    // Clears the byte-offset bits so the address lands on a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// -----------------------------------------------------------------------------
// next_pc_mux
// Combinational next-PC selection for the fetch stage. Priority, highest
// first: jr, jmp, br_taken, sequential. Stall and halt are handled by the
// caller, which decides whether the selected target is used at all.
//
// Ports:
//   i_pc_plus4   - sequential successor of the current PC
//   i_jr         - JR/JALR in ID, target is i_jr_target
//   i_jr_target  - rs register value
//   i_jmp        - J/JAL in ID
//   i_jmp_index  - instr[25:0]
//   i_br_taken   - conditional branch resolved taken in ID
//   i_br_offset  - sign-extended word offset
//   i_id_pc4     - PC+4 of the instruction in ID (redirect base)
//   o_target     - selected next PC (may be misaligned for jr)
//   o_misaligned - o_target[1:0] is non-zero
// -----------------------------------------------------------------------------
module next_pc_mux
    import mips_pkg::*;
(
    input  logic [31:0]            i_pc_plus4,
    input  logic                   i_jr,
    input  logic [31:0]            i_jr_target,
    input  logic                   i_jmp,
    input  logic [JMP_INDEX_W-1:0] i_jmp_index,
    input  logic                   i_br_taken,
    input  logic [31:0]            i_br_offset,
    input  logic [31:0]            i_id_pc4,
    output logic [31:0]            o_target,
    output logic                   o_misaligned
);

    logic [31:0] w_jmp_target;
    logic [31:0] w_br_target;

    // Jump keeps the 256 MB region of the ID-stage PC+4; the branch offset is
    // a word count, so it is scaled by 4 and added with plain 32-bit wrap.
    assign w_jmp_target = {i_id_pc4[31:32-JMP_REGION_W], i_jmp_index, 2'b00};
    assign w_br_target  = i_id_pc4 + (i_br_offset << 2);

    // Priority select; lower-priority redirects presented together are dropped.
    always_comb begin
        o_target = i_pc_plus4;
        if (i_jr) begin
            o_target = i_jr_target;
        end else if (i_jmp) begin
            o_target = w_jmp_target;
        end else if (i_br_taken) begin
            o_target = w_br_target;
        end
    end

    // Only the jr path can actually yield non-zero low bits.
    assign o_misaligned = (o_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter stage of the MIPS32 pipeline. Holds the PC register, the
// BOOT/RUN/HALTED/ERROR control FSM and the sticky misaligned-target flag.
//
// Parameters:
//   RESET_PC    - PC loaded on reset
//   HALT_ON_ERR - 1: misaligned target freezes the PC and enters ERROR
//                 0: misaligned target is force-aligned and fetch continues
//
// Ports:
//   i_clk, i_rst     - rising-edge clock, synchronous active-high reset
//   i_stall          - hazard stall, freezes PC and ignores halt/redirects
//   i_halt           - halt decoded, stop fetching
//   i_br_taken, i_br_offset, i_jmp, i_jmp_index, i_jr, i_jr_target, i_id_pc4
//                    - redirect requests from ID
//   o_pc             - current fetch address (registered)
//   o_pc_plus4       - o_pc + 4 (combinational)
//   o_pc_valid       - FSM in RUN
//   o_halted         - FSM in HALTED
//   o_misalign_err   - sticky misaligned-target flag
// -----------------------------------------------------------------------------
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter bit          HALT_ON_ERR = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_halt,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_offset,
    input  logic        i_jmp,
    input  logic [25:0] i_jmp_index,
    input  logic        i_jr,
    input  logic [31:0] i_jr_target,
    input  logic [31:0] i_id_pc4,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_pc_valid,
    output logic        o_halted,
    output logic        o_misalign_err
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic         r_misalign;
    logic         w_misalign_next;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_target;
    logic         w_misaligned;

    assign w_pc_plus4 = r_pc + PC_INC;

    next_pc_mux u_next_pc_mux (
        .i_pc_plus4   (w_pc_plus4),
        .i_jr         (i_jr),
        .i_jr_target  (i_jr_target),
        .i_jmp        (i_jmp),
        .i_jmp_index  (i_jmp_index),
        .i_br_taken   (i_br_taken),
        .i_br_offset  (i_br_offset),
        .i_id_pc4     (i_id_pc4),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    // Next-state logic. Everything holds by default; only RUN moves the PC.
    // Stall outranks halt so the hazard unit can re-present a halt later.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_misalign_next = r_misalign;
        unique case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (i_stall) begin
                    w_state_next = ST_RUN;
                end else if (i_halt) begin
                    w_state_next = ST_HALTED;
                end else if (w_misaligned) begin
                    w_misalign_next = 1'b1;
                    if (HALT_ON_ERR) begin
                        w_state_next = ST_ERROR;
                    end else begin
                        w_pc_next = align_word(w_target);
                    end
                end else begin
                    w_pc_next = w_target;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            ST_ERROR: begin
                w_state_next = ST_ERROR;
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    // State, PC and sticky flag registers; reset wins over every other input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_misalign <= w_misalign_next;
        end
    end

    assign o_pc           = r_pc;
    assign o_pc_plus4     = w_pc_plus4;
    assign o_pc_valid     = (r_state == ST_RUN);
    assign o_halted       = (r_state == ST_HALTED);
    assign o_misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Self-checking bench for pc_fetch_unit. Three instances share one set of
// inputs: dut0 (RESET_PC=0, HALT_ON_ERR=1), dut1 (RESET_PC=0, HALT_ON_ERR=0)
// and dut2 (RESET_PC=FFFF_FFF8, HALT_ON_ERR=1).
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        halt;
    logic        brTaken;
    logic [31:0] brOffset;
    logic        jmp;
    logic [25:0] jmpIndex;
    logic        jr;
    logic [31:0] jrTarget;
    logic [31:0] idPc4;

    logic [31:0] pc0, pc1, pc2;
    logic [31:0] pcPlus4_0, pcPlus4_1, pcPlus4_2;
    logic        valid0, valid1, valid2;
    logic        halted0, halted1, halted2;
    logic        err0, err1, err2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        halt;
        logic        jr;
        logic [31:0] jrTarget;
        logic        jmp;
        logic [25:0] jmpIndex;
        logic        br;
        logic [31:0] brOffset;
        logic [31:0] idPc4;
        logic [31:0] expPc;
        logic        expValid;
        logic        expHalted;
        logic        expErr;
    } vec_t;

    vec_t vecs [17];

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .HALT_ON_ERR(1'b1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_halt(halt),
        .i_br_taken(brTaken), .i_br_offset(brOffset), .i_jmp(jmp),
        .i_jmp_index(jmpIndex), .i_jr(jr), .i_jr_target(jrTarget),
        .i_id_pc4(idPc4), .o_pc(pc0), .o_pc_plus4(pcPlus4_0),
        .o_pc_valid(valid0), .o_halted(halted0), .o_misalign_err(err0)
    );

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .HALT_ON_ERR(1'b0)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_halt(halt),
        .i_br_taken(brTaken), .i_br_offset(brOffset), .i_jmp(jmp),
        .i_jmp_index(jmpIndex), .i_jr(jr), .i_jr_target(jrTarget),
        .i_id_pc4(idPc4), .o_pc(pc1), .o_pc_plus4(pcPlus4_1),
        .o_pc_valid(valid1), .o_halted(halted1), .o_misalign_err(err1)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .HALT_ON_ERR(1'b1)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_halt(halt),
        .i_br_taken(brTaken), .i_br_offset(brOffset), .i_jmp(jmp),
        .i_jmp_index(jmpIndex), .i_jr(jr), .i_jr_target(jrTarget),
        .i_id_pc4(idPc4), .o_pc(pc2), .o_pc_plus4(pcPlus4_2),
        .o_pc_valid(valid2), .o_halted(halted2), .o_misalign_err(err2)
    );

    // One comparison: bump the counters and report a mismatch on one line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic clearInputs();
        stall    = 1'b0;
        halt     = 1'b0;
        brTaken  = 1'b0;
        brOffset = 32'h0;
        jmp      = 1'b0;
        jmpIndex = 26'h0;
        jr       = 1'b0;
        jrTarget = 32'h0;
        idPc4    = 32'h0;
    endtask

    // Advance one clock and land 1 unit past the rising edge for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        stall    = v.stall;
        halt     = v.halt;
        jr       = v.jr;
        jrTarget = v.jrTarget;
        jmp      = v.jmp;
        jmpIndex = v.jmpIndex;
        brTaken  = v.br;
        brOffset = v.brOffset;
        idPc4    = v.idPc4;
        tick();
    endtask

    // Directed vectors for dut0, starting right after reset (pc=0, BOOT).
    initial begin
        //           stl hlt jr  jrTarget      jmp idx          br  brOffset      idPc4         expPc         v  h  e
        vecs[0]  = '{0, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,        32'h0,        32'h0000_0000, 1, 0, 0};
        vecs[1]  = '{0, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,        32'h0,        32'h0000_0004, 1, 0, 0};
        vecs[2]  = '{0, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,        32'h0,        32'h0000_0008, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,        32'h0,        32'h0000_000C, 1, 0, 0};
        vecs[4]  = '{0, 0, 1, 32'h40,       0, 26'h0,        0, 32'h0,        32'h0,        32'h0000_0040, 1, 0, 0};
        vecs[5]  = '{0, 0, 0, 32'h0,        0, 26'h0,        1, 32'hFFFF_FFFE, 32'h3C,      32'h0000_0034, 1, 0, 0};
        vecs[6]  = '{0, 0, 0, 32'h0,        1, 26'h100,      1, 32'hFFFF_FFFE, 32'h3C,      32'h0000_0400, 1, 0, 0};
        vecs[7]  = '{0, 0, 1, 32'h20,       0, 26'h0,        0, 32'h0,        32'h0,        32'h0000_0020, 1, 0, 0};
        vecs[8]  = '{1, 0, 0, 32'h0,        0, 26'h0,        1, 32'h1,        32'h3C,       32'h0000_0020, 1, 0, 0};
        vecs[9]  = '{1, 0, 0, 32'h0,        0, 26'h0,        1, 32'h1,        32'h3C,       32'h0000_0020, 1, 0, 0};
        vecs[10] = '{1, 0, 0, 32'h0,        0, 26'h0,        1, 32'h1,        32'h3C,       32'h0000_0020, 1, 0, 0};
        vecs[11] = '{0, 0, 0, 32'h0,        0, 26'h0,        1, 32'h1,        32'h3C,       32'h0000_0040, 1, 0, 0};
        vecs[12] = '{1, 1, 0, 32'h0,        0, 26'h0,        0, 32'h0,        32'h0,        32'h0000_0040, 1, 0, 0};
        vecs[13] = '{0, 0, 1, 32'h200,      1, 26'h100,      1, 32'h1,        32'h3C,       32'h0000_0200, 1, 0, 0};
        vecs[14] = '{0, 0, 0, 32'h0,        1, 26'h3FF_FFFF, 0, 32'h0,        32'hF000_0000, 32'hFFFF_FFFC, 1, 0, 0};
        vecs[15] = '{0, 0, 0, 32'h0,        0, 26'h0,        0, 32'h0,        32'h0,        32'h0000_0000, 1, 0, 0};
        vecs[16] = '{0, 0, 0, 32'h0,        0, 26'h0,        1, 32'h2,        32'hFFFF_FFFC, 32'h0000_0004, 1, 0, 0};
    end

    // Main test sequence.
    initial begin
        clearInputs();
        rst = 1'b0;
        #2;

        // Reset state.
        doReset();
        checkOutput("reset pc", pc0, 32'h0);
        checkOutput("reset pc_valid", {31'b0, valid0}, 32'h0);
        checkOutput("reset halted", {31'b0, halted0}, 32'h0);
        checkOutput("reset misalign_err", {31'b0, err0}, 32'h0);
        checkOutput("reset pc_plus4", pcPlus4_0, 32'h4);

        // Table-driven vectors; dut1 must track dut0 since nothing misaligns.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d pc", i), pc0, vecs[i].expPc);
            checkOutput($sformatf("vec%0d pc_valid", i), {31'b0, valid0}, {31'b0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d halted", i), {31'b0, halted0}, {31'b0, vecs[i].expHalted});
            checkOutput($sformatf("vec%0d misalign_err", i), {31'b0, err0}, {31'b0, vecs[i].expErr});
            checkOutput($sformatf("vec%0d pc dut1", i), pc1, vecs[i].expPc);
            checkOutput($sformatf("vec%0d pc_plus4", i), pcPlus4_0, vecs[i].expPc + 32'd4);
        end

        // Misaligned jr: dut0 freezes in ERROR, dut1 force-aligns and keeps going.
        clearInputs();
        jr = 1'b1; jrTarget = 32'h80;
        tick();
        checkOutput("jr 0x80 pc", pc0, 32'h80);
        jrTarget = 32'h1002;
        tick();
        checkOutput("misalign halt pc", pc0, 32'h80);
        checkOutput("misalign halt valid", {31'b0, valid0}, 32'h0);
        checkOutput("misalign halt err", {31'b0, err0}, 32'h1);
        checkOutput("misalign halt halted", {31'b0, halted0}, 32'h0);
        checkOutput("misalign align pc", pc1, 32'h1000);
        checkOutput("misalign align valid", {31'b0, valid1}, 32'h1);
        checkOutput("misalign align err", {31'b0, err1}, 32'h1);
        clearInputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput($sformatf("error hold pc %0d", i), pc0, 32'h80);
            checkOutput($sformatf("error hold err %0d", i), {31'b0, err0}, 32'h1);
            checkOutput($sformatf("error hold valid %0d", i), {31'b0, valid0}, 32'h0);
            checkOutput($sformatf("align run pc %0d", i), pc1, 32'h1004 + 32'(i) * 32'd4);
            checkOutput($sformatf("align sticky err %0d", i), {31'b0, err1}, 32'h1);
        end
        doReset();
        checkOutput("error exit pc", pc0, 32'h0);
        checkOutput("error exit err", {31'b0, err0}, 32'h0);
        checkOutput("error exit valid", {31'b0, valid0}, 32'h0);
        checkOutput("align exit err", {31'b0, err1}, 32'h0);

        // Halt at pc=0x80 then ignore redirects for 10 cycles.
        tick();
        jr = 1'b1; jrTarget = 32'h80;
        tick();
        checkOutput("pre-halt pc", pc0, 32'h80);
        clearInputs();
        halt = 1'b1;
        tick();
        checkOutput("halt pc", pc0, 32'h80);
        checkOutput("halt halted", {31'b0, halted0}, 32'h1);
        checkOutput("halt valid", {31'b0, valid0}, 32'h0);
        halt = 1'b0;
        idPc4 = 32'h3C; brOffset = 32'h1; jmpIndex = 26'h100;
        for (int i = 0; i < 10; i++) begin
            brTaken = i[0];
            jmp     = i[1];
            tick();
            checkOutput($sformatf("halted pc %0d", i), pc0, 32'h80);
            checkOutput($sformatf("halted flag %0d", i), {31'b0, halted0}, 32'h1);
        end
        doReset();
        checkOutput("halt exit pc", pc0, 32'h0);
        checkOutput("halt exit halted", {31'b0, halted0}, 32'h0);

        // Reset asserted during a stall returns to BOOT with RESET_PC.
        tick();
        jr = 1'b1; jrTarget = 32'h300;
        tick();
        clearInputs();
        stall = 1'b1;
        tick();
        checkOutput("stall pc", pc0, 32'h300);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("stall reset pc", pc0, 32'h0);
        checkOutput("stall reset valid", {31'b0, valid0}, 32'h0);

        // Wrap-around from a high reset vector on dut2.
        doReset();
        checkOutput("wrap reset pc", pc2, 32'hFFFF_FFF8);
        checkOutput("wrap reset valid", {31'b0, valid2}, 32'h0);
        tick();
        checkOutput("wrap boot pc", pc2, 32'hFFFF_FFF8);
        checkOutput("wrap boot valid", {31'b0, valid2}, 32'h1);
        tick();
        checkOutput("wrap pc FFFC", pc2, 32'hFFFF_FFFC);
        checkOutput("wrap pc_plus4", pcPlus4_2, 32'h0);
        tick();
        checkOutput("wrap pc 0", pc2, 32'h0);
        checkOutput("wrap no err", {31'b0, err2}, 32'h0);
        tick();
        checkOutput("wrap pc 4", pc2, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so a broken design can never hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
